// File: rtl/button_debounce.sv
// button_debounce: synchronise, debounce and edge-detect a raw push-button pin into clean level and strobes
//   Parameters: DEBOUNCE_CYCLES (stable cycles to accept a change), LONG_CYCLES (held cycles before long_press),
//               ACTIVE_LOW (1: pin reads 0 when pressed).
//   Ports: clk, rst (async, active-high), btn (raw pin) -> pressed (debounced level), press / release_pulse /
//          long_press (one-cycle strobes). The release strobe is named release_pulse because "release" is a
//          reserved word in SystemVerilog.
//   Optional long-press hold counter is built only when BUTTON_DEBOUNCE_LONG_PRESS_EN is defined;
//   otherwise long_press is tied to 0 and LONG_CYCLES is ignored.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LONG_CYCLES = 50000000,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pressed,
  output logic press,
  output logic release_pulse,
  output logic long_press
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] LAST = DW'(DEBOUNCE_CYCLES - 1);
  typedef enum logic [1:0] {RELEASED, ARMING, HELD, DISARMING} state_t;
  state_t state;
  logic [1:0] sync;
  logic [DW-1:0] cnt;
  logic s;
  logic enter_held;
  logic accept_rel;
  assign s = sync[1];
  // The accepting edge is the one where the count would reach DEBOUNCE_CYCLES.
  assign enter_held = state == ARMING && s && cnt == LAST;
  assign accept_rel = state == DISARMING && !s && cnt == LAST;
  always_ff @(posedge clk or posedge rst)
    if (rst) sync <= '0;
    else sync <= {sync[0], btn ^ ACTIVE_LOW};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RELEASED;
      cnt <= '0;
      pressed <= 1'b0;
      press <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        RELEASED:
          if (s) begin
            state <= ARMING;
            cnt <= DW'(1);
          end
        ARMING:
          if (!s) begin
            state <= RELEASED;
            cnt <= '0;
          end else if (enter_held) begin
            state <= HELD;
            cnt <= '0;
            pressed <= 1'b1;
            press <= 1'b1;
          end else cnt <= cnt + 1'b1;
        HELD:
          if (!s) begin
            state <= DISARMING;
            cnt <= DW'(1);
          end
        DISARMING:
          if (s) begin
            state <= HELD;
            cnt <= '0;
          end else if (accept_rel) begin
            state <= RELEASED;
            cnt <= '0;
            pressed <= 1'b0;
            release_pulse <= 1'b1;
          end else cnt <= cnt + 1'b1;
      endcase
    end
  end
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] LONG = HW'(LONG_CYCLES);
  logic [HW-1:0] hold;
  logic counting;
  assign counting = state == HELD || state == DISARMING;
  // Cleared only on a fresh press, so a DISARMING->HELD bounce keeps the count and saturation
  // at LONG blocks repeats until a completed release leads to a new press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold <= '0;
      long_press <= 1'b0;
    end else begin
      long_press <= counting && !accept_rel && hold == LONG - 1'b1;
      hold <= enter_held ? '0 : (counting && hold != LONG) ? hold + 1'b1 : hold;
    end
  end
`else
  assign long_press = 1'b0;
`endif
endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: scoreboard bench for button_debounce with DEBOUNCE_CYCLES=4, LONG_CYCLES=10
module tb_button_debounce;
  localparam int D = 4;
  localparam int L = 10;
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  localparam bit LE = 1'b1;
`else
  localparam bit LE = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  logic btn;
  logic pressed;
  logic press;
  logic release_pulse;
  logic long_press;
  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int np = 0;
  int nr = 0;
  int nl = 0;
  typedef struct {
    int at;
    string tag;
    logic [3:0] v;
  } ev_t;
  ev_t sb[$];
  button_debounce #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk),
    .rst(rst),
    .btn(btn),
    .pressed(pressed),
    .press(press),
    .release_pulse(release_pulse),
    .long_press(long_press)
  );
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @edge %0d: got %0h expected %0h", tag, cyc, got, exp);
  endtask
  task automatic push(int at, string tag, logic [3:0] v);
    ev_t e;
    e.at = at;
    e.tag = tag;
    e.v = v;
    sb.push_back(e);
  endtask
  // Outputs packed as {pressed, press, release, long_press}.
  always @(negedge clk) begin
    np += int'(press);
    nr += int'(release_pulse);
    nl += int'(long_press);
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      ev_t e;
      e = sb.pop_front();
      chk(e.tag, {28'd0, pressed, press, release_pulse, long_press}, {28'd0, e.v});
    end
  end
  task automatic press_items(int n);
    push(n + D + 1, "pre_press", 4'b0000);
    push(n + D + 2, "press", 4'b1100);
    push(n + D + 3, "post_press", 4'b1000);
  endtask
  task automatic drop();
    int m;
    btn = 1'b0;
    m = cyc;
    push(m + D + 1, "pre_release", 4'b1000);
    push(m + D + 2, "release", 4'b0010);
    push(m + D + 3, "post_release", 4'b0000);
    repeat (8) @(negedge clk);
  endtask
  task automatic counts(string tag, int p0, int r0, int l0, int dp, int dr, int dl);
    chk({tag, "_npress"}, np - p0, dp);
    chk({tag, "_nrelease"}, nr - r0, dr);
    chk({tag, "_nlong"}, nl - l0, dl);
  endtask
  task automatic do_press(string tag, int hold, bit from_rst);
    int n, p0, r0, l0;
    p0 = np;
    r0 = nr;
    l0 = nl;
    n = cyc;
    if (from_rst) rst = 1'b0;
    else btn = 1'b1;
    press_items(n);
    if (hold >= 20) begin
      push(n + D + 1 + L, "long_pre", 4'b1000);
      push(n + D + 2 + L, "long", {3'b100, LE});
      push(n + D + 3 + L, "long_post", 4'b1000);
    end
    repeat (hold) @(negedge clk);
    drop();
    counts(tag, p0, r0, l0, 1, 1, (hold >= 20) ? int'(LE) : 0);
  endtask
  initial begin
    int n, n2, p0, r0, l0;
    rst = 1'b1;
    btn = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_outs", {28'd0, pressed, press, release_pulse, long_press}, 32'd0);
    do_press("reset", 8, 1'b1);
    do_press("clean", 20, 1'b0);
    do_press("long", 30, 1'b0);
    do_press("simul", 10, 1'b0);
    p0 = np;
    r0 = nr;
    l0 = nl;
    n = cyc;
    for (int k = 1; k <= 15; k++) push(n + k, "bounce", 4'b0000);
    btn = 1'b1;
    @(negedge clk);
    btn = 1'b0;
    @(negedge clk);
    btn = 1'b1;
    repeat (2) @(negedge clk);
    btn = 1'b0;
    @(negedge clk);
    btn = 1'b1;
    repeat (3) @(negedge clk);
    btn = 1'b0;
    repeat (10) @(negedge clk);
    counts("bounce", p0, r0, l0, 0, 0, 0);
    p0 = np;
    r0 = nr;
    l0 = nl;
    n = cyc;
    btn = 1'b1;
    press_items(n);
    for (int k = D + 4; k < 30; k++) push(n + k, "rel_bounce", {3'b100, LE && k == D + 2 + L});
    repeat (9) @(negedge clk);
    btn = 1'b0;
    repeat (3) @(negedge clk);
    btn = 1'b1;
    repeat (18) @(negedge clk);
    drop();
    counts("rel_bounce", p0, r0, l0, 1, 1, int'(LE));
    p0 = np;
    r0 = nr;
    l0 = nl;
    n = cyc;
    btn = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_outs", {28'd0, pressed, press, release_pulse, long_press}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    n2 = cyc;
    push(n + D + 2, "midrst_no_press", 4'b0000);
    press_items(n2);
    repeat (8) @(negedge clk);
    drop();
    counts("midrst", p0, r0, l0, 1, 1, 0);
    repeat (20) @(negedge clk);
    chk("sb_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
